control_sequencer: RTL and testbench

- Hardwired control unit for the 32-bit bus datapath.
- Fetches each instruction (PC -> MAR -> memory -> MDR -> IR), decodes the opcode in ir[31:27], and steps through T3..T7 execute microsteps.
- Asserts the datapath's register-enable, bus-drive, memory and ALU strobes one microstep per state.
- Replaces the hand-sequenced strobes used in datapath benches today; sits between IR and every datapath control input.

---
 rtl/control_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Hardwired fetch/decode/execute control unit for the 32-bit bus datapath.
// Revision : 1.0
// ============================================================================
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            pco,
  output logic            pc_inc,
  output logic            mari,
  output logic            mdri,
  output logic            mdro,
  output logic            iri,
  output logic            mem_read,
  output logic            mem_write,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            rin,
  output logic            rout,
  output logic            baout,
  output logic            ryi,
  output logic            rzli,
  output logic            rzlo,
  output logic            csigno,
  output logic            ipo,
  output logic            opi,
  output logic            hio,
  output logic            loo,
  output logic [ALUW-1:0] alu_op,
  output logic [3:0]      step,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,  S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4   = 4'd5,  S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd15
  } state_t;

  localparam logic [OPW-1:0] c_OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] c_OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] c_OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] c_OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] c_OP_SUB  = OPW'(4);
  localparam logic [OPW-1:0] c_OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] c_OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] c_OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] c_OP_IN   = OPW'(22);
  localparam logic [OPW-1:0] c_OP_OUT  = OPW'(23);
  localparam logic [OPW-1:0] c_OP_MFHI = OPW'(24);
  localparam logic [OPW-1:0] c_OP_MFLO = OPW'(25);
  localparam logic [OPW-1:0] c_OP_NOP  = OPW'(26);
  localparam logic [OPW-1:0] c_OP_HALT = OPW'(27);

  localparam logic [ALUW-1:0] c_ALU_ADD = ALUW'(0);
  localparam logic [ALUW-1:0] c_ALU_SUB = ALUW'(1);
  localparam logic [ALUW-1:0] c_ALU_AND = ALUW'(2);
  localparam logic [ALUW-1:0] c_ALU_OR  = ALUW'(3);

  state_t         r_state, w_next;
  logic [OPW-1:0] r_opcode;
  logic           r_illegal;
  logic [OPW-1:0] w_ir_op;
  logic           w_ir_legal;
  state_t         w_end;
  logic           w_unused_ir;

  assign w_ir_op     = ir[31:32-OPW];
  assign w_unused_ir = ^ir[31-OPW:0];
  assign w_end       = run ? S_T0 : S_IDLE;

  always_comb begin
    w_ir_legal = 1'b0;
    case (w_ir_op)
      c_OP_LD, c_OP_LDI, c_OP_ST, c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
      c_OP_ADDI, c_OP_IN, c_OP_OUT, c_OP_MFHI, c_OP_MFLO, c_OP_NOP,
      c_OP_HALT: w_ir_legal = 1'b1;
      default:   w_ir_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T2) begin
        r_opcode <= w_ir_op;
        if (!w_ir_legal) r_illegal <= 1'b1;
      end
    end
  end

  // Decode at T2 looks at ir directly because the opcode latches on that same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (run) w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1:   if (mem_ready) w_next = S_T2;
      S_T2: begin
        if (!w_ir_legal || w_ir_op == c_OP_NOP) w_next = w_end;
        else if (w_ir_op == c_OP_HALT)          w_next = S_HALT;
        else                                    w_next = S_T3;
      end
      S_T3: begin
        if (r_opcode == c_OP_IN || r_opcode == c_OP_OUT ||
            r_opcode == c_OP_MFHI || r_opcode == c_OP_MFLO) w_next = w_end;
        else                                                w_next = S_T4;
      end
      S_T4:   w_next = S_T5;
      S_T5:   w_next = (r_opcode == c_OP_LD || r_opcode == c_OP_ST) ? S_T6 : w_end;
      S_T6:   if (r_opcode != c_OP_LD || mem_ready) w_next = S_T7;
      S_T7:   if (r_opcode != c_OP_ST || mem_ready) w_next = w_end;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pco = 1'b0; pc_inc = 1'b0; mari = 1'b0; mdri = 1'b0; mdro = 1'b0; iri = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
    rin = 1'b0; rout = 1'b0; baout = 1'b0; ryi = 1'b0; rzli = 1'b0; rzlo = 1'b0;
    csigno = 1'b0; ipo = 1'b0; opi = 1'b0; hio = 1'b0; loo = 1'b0;
    alu_op = c_ALU_ADD;
    case (r_state)
      S_T0: begin pco = 1'b1; mari = 1'b1; pc_inc = 1'b1; end
      S_T1: begin mem_read = 1'b1; mdri = mem_ready; end
      S_T2: begin mdro = 1'b1; iri = 1'b1; end
      S_T3: begin
        case (r_opcode)
          c_OP_LD, c_OP_LDI, c_OP_ST: begin grb = 1'b1; baout = 1'b1; ryi = 1'b1; end
          c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_ADDI: begin
            grb = 1'b1; rout = 1'b1; ryi = 1'b1;
          end
          c_OP_IN:   begin ipo = 1'b1; gra = 1'b1; rin = 1'b1; end
          c_OP_OUT:  begin gra = 1'b1; rout = 1'b1; opi = 1'b1; end
          c_OP_MFHI: begin hio = 1'b1; gra = 1'b1; rin = 1'b1; end
          c_OP_MFLO: begin loo = 1'b1; gra = 1'b1; rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (r_opcode)
          c_OP_LD, c_OP_LDI, c_OP_ST, c_OP_ADDI: begin csigno = 1'b1; rzli = 1'b1; end
          c_OP_ADD: begin grc = 1'b1; rout = 1'b1; rzli = 1'b1; end
          c_OP_SUB: begin grc = 1'b1; rout = 1'b1; rzli = 1'b1; alu_op = c_ALU_SUB; end
          c_OP_AND: begin grc = 1'b1; rout = 1'b1; rzli = 1'b1; alu_op = c_ALU_AND; end
          c_OP_OR:  begin grc = 1'b1; rout = 1'b1; rzli = 1'b1; alu_op = c_ALU_OR; end
          default: ;
        endcase
      end
      S_T5: begin
        rzlo = 1'b1;
        if (r_opcode == c_OP_LD || r_opcode == c_OP_ST) mari = 1'b1;
        else begin gra = 1'b1; rin = 1'b1; end
      end
      S_T6: begin
        // st loads MDR from the bus, so mem_read stays low and mdri needs no handshake.
        if (r_opcode == c_OP_LD) begin mem_read = 1'b1; mdri = mem_ready; end
        else if (r_opcode == c_OP_ST) begin gra = 1'b1; rout = 1'b1; mdri = 1'b1; end
      end
      S_T7: begin
        if (r_opcode == c_OP_LD) begin mdro = 1'b1; gra = 1'b1; rin = 1'b1; end
        else if (r_opcode == c_OP_ST) mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign step    = r_state;
  assign halted  = (r_state == S_HALT);
  assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Table, directed and randomized self-checking bench for control_sequencer.
// Revision : 1.0
// ============================================================================
module tb_control_sequencer;

  logic clock = 1'b0, clear = 1'b1, run = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic pco, pc_inc, mari, mdri, mdro, iri, mem_read, mem_write, gra, grb, grc;
  logic rin, rout, baout, ryi, rzli, rzlo, csigno, ipo, opi, hio, loo;
  logic [3:0] alu_op, step;
  logic halted, illegal;
  logic [21:0] strobes;

  control_sequencer #(.OPW(5), .ALUW(4)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .pco(pco), .pc_inc(pc_inc), .mari(mari), .mdri(mdri), .mdro(mdro), .iri(iri),
    .mem_read(mem_read), .mem_write(mem_write), .gra(gra), .grb(grb), .grc(grc),
    .rin(rin), .rout(rout), .baout(baout), .ryi(ryi), .rzli(rzli), .rzlo(rzlo),
    .csigno(csigno), .ipo(ipo), .opi(opi), .hio(hio), .loo(loo),
    .alu_op(alu_op), .step(step), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  assign strobes = {pco, pc_inc, mari, mdri, mdro, iri, mem_read, mem_write, gra, grb, grc,
                    rin, rout, baout, ryi, rzli, rzlo, csigno, ipo, opi, hio, loo};

  localparam logic [21:0] M_PCO = 22'h200000, M_PCINC = 22'h100000, M_MARI = 22'h080000;
  localparam logic [21:0] M_MDRI = 22'h040000, M_MDRO = 22'h020000, M_IRI = 22'h010000;
  localparam logic [21:0] M_MRD = 22'h008000, M_MWR = 22'h004000, M_GRA = 22'h002000;
  localparam logic [21:0] M_GRB = 22'h001000, M_GRC = 22'h000800, M_RIN = 22'h000400;
  localparam logic [21:0] M_ROUT = 22'h000200, M_BAOUT = 22'h000100, M_RYI = 22'h000080;
  localparam logic [21:0] M_RZLI = 22'h000040, M_RZLO = 22'h000020, M_CSIGNO = 22'h000010;
  localparam logic [21:0] M_IPO = 22'h000008, M_OPI = 22'h000004, M_HIO = 22'h000002;
  localparam logic [21:0] M_LOO = 22'h000001;

  // wt: 0 = single cycle, 1 = read wait (mdri follows mem_ready), 2 = write wait
  typedef struct { int stp; logic [21:0] m; logic [3:0] alu; int wt; } ustep_t;
  typedef struct { logic [31:0] iv; int cyc; int n_rin; int n_ryi; int n_rd; int n_wr; } vec_t;

  ustep_t plan[$];
  int     n_cmp = 0, n_bad = 0;
  logic   exp_ill = 1'b0;

  function automatic bit legal(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12,
                      5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27};
  endfunction

  function automatic void add(input int s, input logic [21:0] m, input logic [3:0] a, input int w);
    ustep_t e;
    e.stp = s; e.m = m; e.alu = a; e.wt = w;
    plan.push_back(e);
  endfunction

  // Reference: the microstep list each instruction should walk through.
  function automatic void build(input logic [31:0] iv);
    logic [4:0] op;
    op = iv[31:27];
    plan.delete();
    add(1, M_PCO | M_MARI | M_PCINC, 4'd0, 0);
    add(2, M_MRD, 4'd0, 1);
    add(3, M_MDRO | M_IRI, 4'd0, 0);
    case (op)
      5'd0, 5'd1, 5'd2: begin
        add(4, M_GRB | M_BAOUT | M_RYI, 4'd0, 0);
        add(5, M_CSIGNO | M_RZLI, 4'd0, 0);
        if (op == 5'd1) add(6, M_RZLO | M_GRA | M_RIN, 4'd0, 0);
        else add(6, M_RZLO | M_MARI, 4'd0, 0);
        if (op == 5'd0) begin
          add(7, M_MRD, 4'd0, 1);
          add(8, M_MDRO | M_GRA | M_RIN, 4'd0, 0);
        end else if (op == 5'd2) begin
          add(7, M_GRA | M_ROUT | M_MDRI, 4'd0, 0);
          add(8, M_MWR, 4'd0, 2);
        end
      end
      5'd3, 5'd4, 5'd5, 5'd6: begin
        add(4, M_GRB | M_ROUT | M_RYI, 4'd0, 0);
        add(5, M_GRC | M_ROUT | M_RZLI, 4'(op - 5'd3), 0);
        add(6, M_RZLO | M_GRA | M_RIN, 4'd0, 0);
      end
      5'd12: begin
        add(4, M_GRB | M_ROUT | M_RYI, 4'd0, 0);
        add(5, M_CSIGNO | M_RZLI, 4'd0, 0);
        add(6, M_RZLO | M_GRA | M_RIN, 4'd0, 0);
      end
      5'd22: add(4, M_IPO | M_GRA | M_RIN, 4'd0, 0);
      5'd23: add(4, M_GRA | M_ROUT | M_OPI, 4'd0, 0);
      5'd24: add(4, M_HIO | M_GRA | M_RIN, 4'd0, 0);
      5'd25: add(4, M_LOO | M_GRA | M_RIN, 4'd0, 0);
      5'd27: add(15, 22'd0, 4'd0, 0);
      default: ;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] exp);
    logic [31:0] act;
    act = {step, halted, illegal, alu_op, strobes};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Entered just after a rising edge with the DUT in T0; leaves it the same way.
  // delay < 0 randomizes mem_ready, otherwise each wait state sees it low for delay cycles.
  task automatic run_instr(input logic [31:0] iv, input int delay, input bit keep_run);
    ustep_t e;
    int cnt;
    logic rdy;
    bit saw_halt;
    cnt = 0; saw_halt = 0;
    ir = iv; run = keep_run;
    build(iv);
    while (plan.size() > 0) begin
      e = plan[0];
      if (delay < 0) rdy = 1'($urandom % 2);
      else if (e.wt != 0) rdy = (cnt == delay);
      else rdy = 1'b1;
      mem_ready = rdy;
      @(negedge clock); #1;
      check($sformatf("op%0d_T%0d", iv[31:27], e.stp - 1),
            {4'(e.stp), 1'(e.stp == 15), exp_ill, e.alu,
             e.m | ((e.wt == 1 && rdy) ? M_MDRI : 22'd0)});
      @(posedge clock); #1;
      if (e.wt == 0 || rdy) begin
        if (e.stp == 3 && !legal(iv[31:27])) exp_ill = 1'b1;
        if (e.stp == 15) saw_halt = 1;
        void'(plan.pop_front());
        cnt = 0;
      end else begin
        cnt++;
        if (cnt > 64) begin
          n_cmp++; n_bad++;
          $display("FAIL wait_timeout: step %0d stuck, limit 64 cycles", step);
          summary();
          $fatal(1, "wait bound expired");
        end
      end
    end
    if (!keep_run && !saw_halt) begin
      @(negedge clock); #1;
      check("idle_after_run_low", {4'd0, 1'b0, exp_ill, 4'd0, 22'd0});
      run = 1'b1;
      @(posedge clock); #1;
    end
  endtask

  vec_t tbl[11];
  logic [4:0] legal_ops[14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12,
                                5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd26};

  initial begin
    tbl[0]  = '{32'h0880_0005, 6, 1, 1, 1, 0};
    tbl[1]  = '{32'h0000_0000, 8, 1, 1, 2, 0};
    tbl[2]  = '{32'h1000_0000, 8, 0, 1, 1, 1};
    tbl[3]  = '{32'h1800_0000, 6, 1, 1, 1, 0};
    tbl[4]  = '{32'h2800_0000, 6, 1, 1, 1, 0};
    tbl[5]  = '{32'h6000_0000, 6, 1, 1, 1, 0};
    tbl[6]  = '{32'hB000_0000, 4, 1, 0, 1, 0};
    tbl[7]  = '{32'hB800_0000, 4, 0, 0, 1, 0};
    tbl[8]  = '{32'hC000_0000, 4, 1, 0, 1, 0};
    tbl[9]  = '{32'hC800_0000, 4, 1, 0, 1, 0};
    tbl[10] = '{32'hD000_0000, 3, 0, 0, 1, 0};

    repeat (3) @(posedge clock);
    #1;
    @(negedge clock); #1;
    check("reset_state", 32'd0);
    clear = 1'b0;
    @(posedge clock); #1;
    @(negedge clock); #1;
    check("idle_hold_run0", 32'd0);
    run = 1'b1;
    @(posedge clock); #1;

    run_instr(32'h0880_0005, 0, 1'b1);

    for (int i = 0; i < 11; i++) begin
      int cyc, nrin, nryi, nrd, nwr;
      cyc = 0; nrin = 0; nryi = 0; nrd = 0; nwr = 0;
      ir = tbl[i].iv; mem_ready = 1'b1; run = 1'b1;
      for (int k = 0; k < 40; k++) begin
        if (k > 0 && step == 4'd1) break;
        @(negedge clock); #1;
        cyc++; nrin += int'(rin); nryi += int'(ryi); nrd += int'(mem_read); nwr += int'(mem_write);
        @(posedge clock); #1;
      end
      check_int($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      check_int($sformatf("tbl%0d_rin_ryi_rd_wr", i), nrin * 1000 + nryi * 100 + nrd * 10 + nwr,
                tbl[i].n_rin * 1000 + tbl[i].n_ryi * 100 + tbl[i].n_rd * 10 + tbl[i].n_wr);
    end

    run_instr(32'h0000_0000, 3, 1'b1);
    run_instr(32'h2000_0000, 0, 1'b1);
    run_instr(32'h1000_0000, 2, 1'b1);

    // Clear while ld sits in its data-read wait.
    ir = 32'h0000_0000; mem_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    mem_ready = 1'b0;
    @(negedge clock); #1;
    check("ld_T6_before_clear", {4'd7, 1'b0, exp_ill, 4'd0, M_MRD});
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0; exp_ill = 1'b0;
    @(negedge clock); #1;
    check("after_clear_mid_ld", 32'd0);
    @(posedge clock); #1;
    run_instr(32'h0880_0005, 0, 1'b1);

    for (int n = 0; n < 150; n++) begin
      logic [4:0] op;
      if ($urandom % 8 == 0) op = ($urandom % 2 == 0) ? 5'(28 + $urandom_range(0, 3))
                                                       : 5'($urandom_range(7, 11));
      else op = legal_ops[$urandom_range(0, 13)];
      run_instr({op, 27'($urandom)}, -1, ($urandom % 4) != 0);
    end

    run_instr(32'hF800_0000, 0, 1'b1);
    run_instr(32'hD000_0000, 0, 1'b1);
    run_instr(32'hD800_0000, 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run = k[0]; mem_ready = 1'($urandom % 2);
      @(negedge clock); #1;
      check($sformatf("halt_hold%0d", k), {4'd15, 1'b1, 1'b1, 4'd0, 22'd0});
      @(posedge clock); #1;
    end
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0; run = 1'b0; exp_ill = 1'b0;
    @(negedge clock); #1;
    check("clear_exits_halt", 32'd0);

    summary();
    $finish;
  end

endmodule
`default_nettype wire
